// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: synchronizes root reset deassertion, releases channels in
// order at fixed intervals, and supports per-channel software reset pulses.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_RST  | synchronized reset just released; first counting edge
// ST_SEQ  | releasing channels one by one every STEP cycles
// ST_DONE | all channels released; software pulses may run
module rst_seq_ctrl #(
   parameter int SYN_NUM = 3,
   parameter int CH_NUM  = 4,
   parameter int STEP    = 4,
   parameter int SW_LEN  = 8
) (
   input  logic              i_clk,
   input  logic              i_rstn,
   input  logic              i_dft_mode,
   input  logic              i_dft_rstn,
   input  logic              i_scan_mode,
   input  logic [CH_NUM-1:0] i_sw_rst_req,
   output logic [CH_NUM-1:0] o_rstn,
   output logic              o_done
);

   localparam int CW  = $clog2(STEP + 1);
   localparam int IW  = $clog2(CH_NUM + 1);
   localparam int SWW = $clog2(SW_LEN + 1);

   typedef enum logic [1:0] {ST_RST, ST_SEQ, ST_DONE} state_t;

   logic                          root_rstn;
   logic                          sync_rstn;
   logic [SYN_NUM-1:0]            sync_q, sync_d;
   state_t                        state_q, state_d;
   logic [CW-1:0]                 cnt_q, cnt_d, cur_cnt;
   logic [IW-1:0]                 idx_q, idx_d, cur_idx;
   logic [CH_NUM-1:0][SWW-1:0]    sw_cnt_q, sw_cnt_d;
   logic [CH_NUM-1:0]             chn_q, chn_d;
   logic [CH_NUM-1:0]             rel_now, rel_nxt;
   logic                          done_q, done_d;
   logic                          any_pulse;

   assign root_rstn = i_dft_mode ? i_dft_rstn : i_rstn;
   assign sync_d    = {sync_q[SYN_NUM-2:0], 1'b1};
   assign sync_rstn = sync_q[SYN_NUM-1];

   always_ff @(posedge i_clk or negedge root_rstn) begin
      if (!root_rstn) sync_q <= '0;
      else            sync_q <= sync_d;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      sw_cnt_d  = sw_cnt_q;
      chn_d     = '0;
      rel_now   = '0;
      rel_nxt   = '0;
      any_pulse = 1'b0;
      // The RST->SEQ edge is itself the first counting edge, which puts
      // channel k's release exactly (k+1)*STEP edges after sync_rstn rises.
      cur_cnt   = (state_q == ST_RST) ? '0 : cnt_q;
      cur_idx   = (state_q == ST_RST) ? '0 : idx_q;

      if (state_q != ST_DONE) begin
         if (cur_cnt == CW'(STEP - 1)) begin
            cnt_d   = '0;
            idx_d   = cur_idx + IW'(1);
            state_d = (cur_idx == IW'(CH_NUM - 1)) ? ST_DONE : ST_SEQ;
         end else begin
            cnt_d   = cur_cnt + CW'(1);
            idx_d   = cur_idx;
            state_d = ST_SEQ;
         end
      end

      for (int k = 0; k < CH_NUM; k++) begin
         rel_now[k] = (state_q == ST_DONE) || ((state_q == ST_SEQ) && (IW'(k) < idx_q));
         rel_nxt[k] = (state_d == ST_DONE) || ((state_d == ST_SEQ) && (IW'(k) < idx_d));
         if (i_sw_rst_req[k] && rel_now[k])
            sw_cnt_d[k] = SWW'(SW_LEN);
         else if (sw_cnt_q[k] != '0)
            sw_cnt_d[k] = sw_cnt_q[k] - SWW'(1);
         else
            sw_cnt_d[k] = '0;
         chn_d[k] = rel_nxt[k] && (sw_cnt_d[k] == '0);
         if (sw_cnt_d[k] != '0) any_pulse = 1'b1;
      end

      done_d = (state_q == ST_DONE) && !any_pulse;
   end

   always_ff @(posedge i_clk or negedge sync_rstn) begin
      if (!sync_rstn) begin
         state_q  <= ST_RST;
         cnt_q    <= '0;
         idx_q    <= '0;
         sw_cnt_q <= '0;
         chn_q    <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         sw_cnt_q <= sw_cnt_d;
         chn_q    <= chn_d;
         done_q   <= done_d;
      end
   end

   assign o_rstn = i_scan_mode ? {CH_NUM{i_dft_rstn}} : chn_q;
   assign o_done = done_q;

endmodule

// File: doc/rst_seq_ctrl.md
RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 SHALL have parameter SYN_NUM, default 3, giving the synchronizer depth (legal values >= 2).
REQ-002 SHALL have parameter CH_NUM, default 4, giving the number of reset channels (legal values >= 1).
REQ-003 SHALL have parameter STEP, default 4, giving the clock cycles between successive channel releases (legal values >= 1).
REQ-004 SHALL have parameter SW_LEN, default 8, giving the software reset pulse length in cycles (legal values >= 1).
REQ-005 SHALL have port i_clk, input, width 1: the single clock.
REQ-006 SHALL have port i_rstn, input, width 1: the root reset, asynchronous and active-low.
REQ-007 SHALL have port i_dft_mode, input, width 1: when 1, selects i_dft_rstn as the root reset.
REQ-008 SHALL have port i_dft_rstn, input, width 1: the DFT reset, active-low.
REQ-009 SHALL have port i_scan_mode, input, width 1: when 1, drives every o_rstn bit directly from i_dft_rstn.
REQ-010 SHALL have port i_sw_rst_req, input, width CH_NUM: per-channel software reset request, synchronous to i_clk, level-sampled every cycle.
REQ-011 SHALL have port o_rstn, output, width CH_NUM: per-channel reset, active-low.
REQ-012 SHALL have port o_done, output, width 1: 1 when the release sequence is complete and no software pulse is active.

Function
REQ-013 SHALL form root_rstn = i_dft_mode ? i_dft_rstn : i_rstn.
REQ-014 SHALL synchronize the deassertion of root_rstn through an SYN_NUM-flop chain that is cleared asynchronously by root_rstn; the chain output is sync_rstn.
REQ-015 SHALL implement an FSM with states RST, SEQ and DONE; all state, counters and channel flops SHALL be cleared asynchronously by sync_rstn low.
REQ-016 RST -> SEQ SHALL occur on the first edge at which sync_rstn=1; this clears the step counter cnt and the channel index idx.
REQ-017 In SEQ, cnt SHALL increment every cycle; when cnt==STEP-1, channel idx SHALL be released, idx SHALL increment and cnt SHALL return to 0.
REQ-018 Release of channel CH_NUM-1 SHALL move the FSM to DONE on the same edge; channels SHALL release strictly in order 0 to CH_NUM-1.
REQ-019 Timing: if E0 is the edge at which sync_rstn rises, channel k SHALL rise at edge E0 + (k+1)*STEP.
REQ-020 Each o_rstn bit SHALL come directly from a flop, with no combinational glitch path except the scan mux.
REQ-021 A software reset request on a channel that is already released SHALL drive o_rstn[k] low on the next edge and hold it low for exactly SW_LEN cycles, then drive it high.
REQ-022 A request on channel k during an active pulse on k SHALL reload that channel's counter, extending the pulse to SW_LEN cycles after the last sampled request.
REQ-023 A request on a channel not yet released SHALL be ignored.
REQ-024 Simultaneous requests on several channels SHALL be handled independently, with one counter per channel.
REQ-025 o_done SHALL equal (state==DONE) AND (no software pulse active), and SHALL be registered.
REQ-026 o_rstn SHALL equal i_scan_mode ? {CH_NUM{i_dft_rstn}} : chn_q.

Reset
REQ-027 root_rstn low SHALL, asynchronously, drive all o_rstn bits to 0 and o_done to 0, set the FSM to RST and clear all counters.
REQ-028 Root reset assertion mid-sequence or mid-pulse SHALL abort the operation; a new full sequence SHALL start after the root reset deasserts.
REQ-029 Reset values SHALL be: o_rstn = 0, o_done = 0, state = RST, cnt = 0, idx = 0, all software counters = 0.

Verification
REQ-030 Power-up with defaults: deassert i_rstn before edge 1 -> o_rstn = 0001 at edge 7, 0011 at edge 11, 0111 at edge 15, 1111 at edge 19, and o_done = 1 at edge 20.
REQ-031 Software pulse: in DONE, request bit 2 high for 1 cycle -> o_rstn[2] = 0 for 8 cycles, then 1; o_done = 0 during the pulse; other bits stay at 1.
REQ-032 Extension and ignored request: re-request bit 2 at pulse cycle 5 -> low for 13 cycles in total; a request on bit 3 at edge 12 (not yet released) -> no effect.
REQ-033 Mid-sequence abort: drop i_rstn at edge 13 -> o_rstn = 0000 asynchronously; release i_rstn -> full sequence restarts from channel 0 with REQ-019 timing.
REQ-034 DFT: i_dft_mode=1 with i_dft_rstn toggled -> sequencing follows i_dft_rstn and ignores i_rstn; i_scan_mode=1 -> o_rstn = {4{i_dft_rstn}} combinationally.
